// File: rtl/parking_system.sv
// Parking-lot occupancy manager: capacity/free-slot counting driven by gate edges,
// two-digit 7-segment free-slot readout and a divided slow clock.
module parking_system #(
    parameter int SLOW_HALF = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_slots,
    input  logic [3:0] num_slots,
    input  logic       start,
    input  logic       inc_car,
    input  logic       dec_car,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [3:0] free_slots,
    output logic       slow_clk
);

    localparam int CW = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(SLOW_HALF - 1);

    logic [3:0]    total;
    logic          inc_prev;
    logic          dec_prev;
    logic          inc_rise;
    logic          dec_rise;
    logic [CW-1:0] div_cnt;
    logic [3:0]    units;
    logic          tens;

    assign inc_rise = inc_car & ~inc_prev;
    assign dec_rise = dec_car & ~dec_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            total      <= 4'd0;
            free_slots <= 4'd0;
            inc_prev   <= 1'b0;
            dec_prev   <= 1'b0;
        end else begin
            inc_prev <= inc_car;
            dec_prev <= dec_car;
            if (start) begin
                // Simultaneous entry and exit cancel out.
                if (inc_rise && !dec_rise
                    && free_slots != 4'd0)
                    free_slots <= free_slots - 4'd1;
                else if (dec_rise && !inc_rise
                         && free_slots < total)
                    free_slots <= free_slots + 4'd1;
            end else if (set_slots) begin
                total      <= num_slots;
                free_slots <= num_slots;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt  <= '0;
            slow_clk <= 1'b0;
        end else if (div_cnt == LAST) begin
            div_cnt  <= '0;
            slow_clk <= ~slow_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    function automatic logic [6:0] seg7(
        input logic [3:0] d
    );
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    assign tens  = (free_slots >= 4'd10);
    assign units = tens ? (free_slots - 4'd10)
                        : free_slots;

    assign seg1 = seg7({3'b000, tens});
    assign seg2 = seg7(units);

endmodule

// File: tb/tb_parking_system.sv
// Scoreboard bench for parking_system: a reference model queues the expected
// outputs for every driven cycle, which are popped and compared after the edge.
module tb_parking_system;

    localparam int SH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       set_slots = 1'b0;
    logic [3:0] num_slots = 4'd0;
    logic       start = 1'b0;
    logic       inc_car = 1'b0;
    logic       dec_car = 1'b0;
    logic [6:0] seg1;
    logic [6:0] seg2;
    logic [3:0] free_slots;
    logic       slow_clk;

    parking_system #(.SLOW_HALF(SH)) dut (
        .clk       (clk),
        .reset     (reset),
        .set_slots (set_slots),
        .num_slots (num_slots),
        .start     (start),
        .inc_car   (inc_car),
        .dec_car   (dec_car),
        .seg1      (seg1),
        .seg2      (seg2),
        .free_slots(free_slots),
        .slow_clk  (slow_clk)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] free;
        logic [6:0] s1;
        logic [6:0] s2;
        logic       sc;
    } exp_t;

    exp_t q[$];

    logic [6:0] seg_tab [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011,
        7'b1001111, 7'b1100110, 7'b1101101,
        7'b1111101, 7'b0000111, 7'b1111111,
        7'b1101111
    };

    int n_checks = 0;
    int n_fail   = 0;

    int m_total = 0;
    int m_free  = 0;
    int m_cnt   = 0;
    bit m_ip    = 0;
    bit m_dp    = 0;
    bit m_sc    = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit ir;
        bit dr;
        exp_t e;
        if (reset) begin
            m_total = 0; m_free = 0;
            m_ip = 0; m_dp = 0;
            m_cnt = 0; m_sc = 0;
        end else begin
            ir = inc_car && !m_ip;
            dr = dec_car && !m_dp;
            if (start) begin
                if (ir && !dr && m_free > 0)
                    m_free--;
                else if (dr && !ir && m_free < m_total)
                    m_free++;
            end else if (set_slots) begin
                m_total = int'(num_slots);
                m_free  = int'(num_slots);
            end
            m_ip = inc_car;
            m_dp = dec_car;
            if (m_cnt == SH - 1) begin
                m_cnt = 0;
                m_sc  = !m_sc;
            end else begin
                m_cnt++;
            end
        end
        e.free = 4'(m_free);
        e.s1   = seg_tab[m_free / 10];
        e.s2   = seg_tab[m_free % 10];
        e.sc   = m_sc;
        q.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            e = q.pop_front();
            check("free_slots", 32'(free_slots), 32'(e.free));
            check("seg1", 32'(seg1), 32'(e.s1));
            check("seg2", 32'(seg2), 32'(e.s2));
            check("slow_clk", 32'(slow_clk), 32'(e.sc));
        end
    endtask

    task automatic pulse_inc();
        inc_car = 1'b1; tick();
        inc_car = 1'b0; tick();
    endtask

    task automatic pulse_dec();
        dec_car = 1'b1; tick();
        dec_car = 1'b0; tick();
    endtask

    initial begin
        // Reset and idle, slow clock phase
        reset = 1'b1; tick();
        reset = 1'b0;
        check("rst_free", 32'(free_slots), 32'd0);
        check("rst_seg1", 32'(seg1), 32'h3f);
        check("rst_seg2", 32'(seg2), 32'h3f);
        check("rst_slow", 32'(slow_clk), 32'd0);
        tick(3);
        check("slow_pre", 32'(slow_clk), 32'd0);
        tick();
        check("slow_hi", 32'(slow_clk), 32'd1);
        tick(4);
        check("slow_lo", 32'(slow_clk), 32'd0);

        // Configure ten slots
        set_slots = 1'b1; num_slots = 4'd10; tick();
        set_slots = 1'b0; num_slots = 4'd3; tick(2);
        check("cfg_free", 32'(free_slots), 32'd10);
        check("cfg_seg1", 32'(seg1), 32'h06);
        check("cfg_seg2", 32'(seg2), 32'h3f);

        // Held entry counts once, exit limited by capacity
        start = 1'b1;
        inc_car = 1'b1; tick(10);
        inc_car = 1'b0; tick();
        check("held_inc", 32'(free_slots), 32'd9);
        pulse_dec();
        check("dec_back", 32'(free_slots), 32'd10);
        pulse_dec();
        check("dec_cap", 32'(free_slots), 32'd10);

        // Full lot with capacity two
        start = 1'b0; set_slots = 1'b1;
        num_slots = 4'd2; tick();
        set_slots = 1'b0; start = 1'b1;
        pulse_inc();
        check("full_1", 32'(free_slots), 32'd1);
        pulse_inc();
        check("full_0", 32'(free_slots), 32'd0);
        pulse_inc();
        check("full_nowrap", 32'(free_slots), 32'd0);
        pulse_dec();
        inc_car = 1'b1; dec_car = 1'b1; tick();
        inc_car = 1'b0; dec_car = 1'b0; tick();
        check("both_edges", 32'(free_slots), 32'd1);

        // Gating
        start = 1'b0;
        pulse_inc();
        check("idle_inc", 32'(free_slots), 32'd1);
        start = 1'b1; set_slots = 1'b1;
        num_slots = 4'd5; tick(2);
        set_slots = 1'b0;
        check("set_in_run", 32'(free_slots), 32'd1);
        pulse_dec();
        check("total_kept", 32'(free_slots), 32'd2);

        // Reset mid-run
        start = 1'b0; set_slots = 1'b1;
        num_slots = 4'd7; tick();
        set_slots = 1'b0; start = 1'b1; tick();
        check("pre_rst", 32'(free_slots), 32'd7);
        reset = 1'b1; tick();
        reset = 1'b0;
        check("mid_rst", 32'(free_slots), 32'd0);
        pulse_dec();
        check("rst_total0", 32'(free_slots), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 60) == 0);
            set_slots = $urandom_range(0, 7) == 0;
            start     = $urandom_range(0, 3) != 0;
            num_slots = 4'($urandom_range(0, 15));
            inc_car   = $urandom_range(0, 1) == 1;
            dec_car   = $urandom_range(0, 2) == 0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
